pipe_stage_buffer: RTL and testbench

- Parametrised, handshaked successor to the fixed-field inter-stage pipeline registers, with a generic DATA_W payload.
- Adds a valid bit, ready/valid back-pressure, an optional 2-entry skid buffer, a synchronous flush that inserts bubbles, and a saturating stall-cycle counter.
- Instantiated between any two core stages (IF/ID, ID/EXE, EXE/MEM, MEM/WB); the stage's field bundle is concatenated onto data_i.

---
 rtl/pipe_stage_buffer.sv | 86 ++++++++
 tb/tb_pipe_stage_buffer.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/pipe_stage_buffer.sv
// pipe_stage_buffer: ready/valid inter-stage register with optional skid entry,
// synchronous flush and a saturating stall-cycle counter.
module pipe_stage_buffer #(
    parameter int unsigned DATA_W  = 96,
    parameter bit          SKID_EN = 1'b1,
    parameter int unsigned CNT_W   = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] data_i,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] data_o,
    input  logic              hold,
    input  logic              flush,
    output logic [1:0]        occupancy,
    output logic [CNT_W-1:0]  stall_cnt
);
    logic              main_valid_q, main_valid_d, skid_valid_q, skid_valid_d;
    logic              in_ready_q, in_ready_d;
    logic [DATA_W-1:0] main_data_q, main_data_d, skid_data_q, skid_data_d;
    logic [1:0]        occ_q, occ_d;
    logic [CNT_W-1:0]  stall_q, stall_d;
    logic              in_fire, out_fire;

    assign out_fire  = main_valid_q & out_ready & ~hold;
    assign in_ready  = SKID_EN ? in_ready_q : (~main_valid_q | out_fire);
    assign in_fire   = in_valid & in_ready;
    assign out_valid = main_valid_q;
    assign data_o    = main_data_q;
    assign occupancy = occ_q;
    assign stall_cnt = stall_q;

    // Pop first so a same-cycle push lands in whichever entry the pop just freed.
    always_comb begin
        main_valid_d = main_valid_q;
        main_data_d  = main_data_q;
        skid_valid_d = skid_valid_q;
        skid_data_d  = skid_data_q;
        if (out_fire) begin
            main_valid_d = skid_valid_q;
            main_data_d  = skid_data_q;
            skid_valid_d = 1'b0;
        end
        if (in_fire) begin
            if (!main_valid_d) begin
                main_valid_d = 1'b1;
                main_data_d  = data_i;
            end else if (SKID_EN) begin
                skid_valid_d = 1'b1;
                skid_data_d  = data_i;
            end
        end
        if (flush) begin
            main_valid_d = 1'b0;
            skid_valid_d = 1'b0;
        end
        in_ready_d = ~skid_valid_d;
        occ_d      = {1'b0, main_valid_d} + {1'b0, skid_valid_d};
        stall_d    = (main_valid_q & ~out_fire & ~flush & ~(&stall_q)) ? stall_q + 1'b1 : stall_q;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            main_valid_q <= 1'b0;
            skid_valid_q <= 1'b0;
            main_data_q  <= '0;
            skid_data_q  <= '0;
            in_ready_q   <= 1'b1;
            occ_q        <= 2'd0;
            stall_q      <= '0;
        end else begin
            main_valid_q <= main_valid_d;
            skid_valid_q <= skid_valid_d;
            main_data_q  <= main_data_d;
            skid_data_q  <= skid_data_d;
            in_ready_q   <= in_ready_d;
            occ_q        <= occ_d;
            stall_q      <= stall_d;
        end
    end

    assert property (@(posedge clk) disable iff (!rst) skid_valid_q |-> main_valid_q);
endmodule

// File: tb/tb_pipe_stage_buffer.sv
// tb_pipe_stage_buffer: directed checks of a skid instance, a no-skid instance
// and a 4-bit stall counter instance driven by shared stimulus.
module tb_pipe_stage_buffer;
    logic       clk = 1'b0, rst = 1'b0, in_valid = 1'b0, out_ready = 1'b0, hold = 1'b0, flush = 1'b0;
    logic [7:0] data_i = 8'h00;
    logic       a_in_ready, a_out_valid, n_in_ready, n_out_valid, c_in_ready, c_out_valid;
    logic [7:0] a_data_o, n_data_o, c_data_o;
    logic [1:0] a_occ, n_occ, c_occ;
    logic [15:0] a_stall, n_stall;
    logic [3:0] c_stall;
    int checks = 0, failures = 0;

    always #5 clk = ~clk;

    pipe_stage_buffer #(.DATA_W(8), .SKID_EN(1'b1), .CNT_W(16)) u_a (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(a_in_ready), .data_i(data_i),
        .out_valid(a_out_valid), .out_ready(out_ready), .data_o(a_data_o), .hold(hold),
        .flush(flush), .occupancy(a_occ), .stall_cnt(a_stall));

    pipe_stage_buffer #(.DATA_W(8), .SKID_EN(1'b0), .CNT_W(16)) u_n (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(n_in_ready), .data_i(data_i),
        .out_valid(n_out_valid), .out_ready(out_ready), .data_o(n_data_o), .hold(hold),
        .flush(flush), .occupancy(n_occ), .stall_cnt(n_stall));

    pipe_stage_buffer #(.DATA_W(8), .SKID_EN(1'b1), .CNT_W(4)) u_c (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(c_in_ready), .data_i(data_i),
        .out_valid(c_out_valid), .out_ready(out_ready), .data_o(c_data_o), .hold(hold),
        .flush(flush), .occupancy(c_occ), .stall_cnt(c_stall));

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        in_valid = 1'b0; out_ready = 1'b0; hold = 1'b0; flush = 1'b0; data_i = 8'h00;
        rst = 1'b0;
        cyc(1);
        rst = 1'b1;
        cyc(1);
    endtask

    task automatic test_reset();
        cyc(1);
        checks++; if (a_out_valid !== 1'b0) begin failures++; $display("FAIL rst_out_valid got=%0d exp=0", a_out_valid); end
        checks++; if (a_in_ready !== 1'b1) begin failures++; $display("FAIL rst_in_ready got=%0d exp=1", a_in_ready); end
        checks++; if (n_in_ready !== 1'b1) begin failures++; $display("FAIL rst_n_in_ready got=%0d exp=1", n_in_ready); end
        checks++; if (a_occ !== 2'd0) begin failures++; $display("FAIL rst_occ got=%0d exp=0", a_occ); end
        checks++; if (a_stall !== 16'd0) begin failures++; $display("FAIL rst_stall got=%0d exp=0", a_stall); end
        checks++; if (a_data_o !== 8'h00) begin failures++; $display("FAIL rst_data got=%0h exp=0", a_data_o); end
        rst = 1'b1;
        cyc(1);
    endtask

    task automatic test_single();
        do_reset();
        in_valid = 1'b1; data_i = 8'hA5; out_ready = 1'b1;
        cyc(1);
        in_valid = 1'b0;
        checks++; if (a_out_valid !== 1'b1) begin failures++; $display("FAIL single_valid got=%0d exp=1", a_out_valid); end
        checks++; if (a_data_o !== 8'hA5) begin failures++; $display("FAIL single_data got=%0h exp=a5", a_data_o); end
        checks++; if (a_occ !== 2'd1) begin failures++; $display("FAIL single_occ got=%0d exp=1", a_occ); end
        cyc(1);
        checks++; if (a_out_valid !== 1'b0) begin failures++; $display("FAIL single_drain got=%0d exp=0", a_out_valid); end
        checks++; if (a_occ !== 2'd0) begin failures++; $display("FAIL single_occ0 got=%0d exp=0", a_occ); end
    endtask

    task automatic test_back_to_back();
        do_reset();
        out_ready = 1'b1; in_valid = 1'b1;
        for (int k = 1; k <= 8; k++) begin
            data_i = 8'(k);
            checks++; if (a_in_ready !== 1'b1) begin failures++; $display("FAIL stream_ready[%0d] got=%0d exp=1", k, a_in_ready); end
            cyc(1);
            checks++; if ({a_out_valid, a_data_o} !== {1'b1, 8'(k)}) begin failures++; $display("FAIL stream_data[%0d] got=%0d/%0h exp=1/%0h", k, a_out_valid, a_data_o, k); end
        end
        in_valid = 1'b0;
        cyc(1);
        checks++; if (a_out_valid !== 1'b0) begin failures++; $display("FAIL stream_end got=%0d exp=0", a_out_valid); end
    endtask

    task automatic test_backpressure();
        do_reset();
        in_valid = 1'b1; data_i = 8'h11;
        cyc(1);
        data_i = 8'h22;
        cyc(1);
        checks++; if (a_occ !== 2'd2) begin failures++; $display("FAIL bp_occ2 got=%0d exp=2", a_occ); end
        checks++; if (a_in_ready !== 1'b0) begin failures++; $display("FAIL bp_ready0 got=%0d exp=0", a_in_ready); end
        checks++; if (a_data_o !== 8'h11) begin failures++; $display("FAIL bp_head got=%0h exp=11", a_data_o); end
        data_i = 8'h44;
        cyc(1);
        in_valid = 1'b0;
        checks++; if (a_occ !== 2'd2) begin failures++; $display("FAIL bp_third got=%0d exp=2", a_occ); end
        out_ready = 1'b1;
        cyc(1);
        checks++; if (a_data_o !== 8'h22) begin failures++; $display("FAIL bp_second got=%0h exp=22", a_data_o); end
        checks++; if (a_in_ready !== 1'b1) begin failures++; $display("FAIL bp_ready1 got=%0d exp=1", a_in_ready); end
        checks++; if (a_occ !== 2'd1) begin failures++; $display("FAIL bp_occ1 got=%0d exp=1", a_occ); end
        cyc(1);
        checks++; if ({a_out_valid, a_occ} !== 3'b000) begin failures++; $display("FAIL bp_empty got=%0d/%0d exp=0/0", a_out_valid, a_occ); end
    endtask

    task automatic test_noskid();
        do_reset();
        in_valid = 1'b1; data_i = 8'h5A;
        cyc(1);
        checks++; if ({n_occ, n_data_o} !== {2'd1, 8'h5A}) begin failures++; $display("FAIL ns_load got=%0d/%0h exp=1/5a", n_occ, n_data_o); end
        data_i = 8'h6B;
        #1;
        checks++; if (n_in_ready !== 1'b0) begin failures++; $display("FAIL ns_ready0 got=%0d exp=0", n_in_ready); end
        cyc(1);
        checks++; if ({n_occ, n_data_o} !== {2'd1, 8'h5A}) begin failures++; $display("FAIL ns_block got=%0d/%0h exp=1/5a", n_occ, n_data_o); end
        out_ready = 1'b1;
        #1;
        checks++; if (n_in_ready !== 1'b1) begin failures++; $display("FAIL ns_ready_comb got=%0d exp=1", n_in_ready); end
        cyc(1);
        checks++; if ({n_out_valid, n_data_o} !== {1'b1, 8'h6B}) begin failures++; $display("FAIL ns_replace got=%0d/%0h exp=1/6b", n_out_valid, n_data_o); end
        in_valid = 1'b0;
        cyc(1);
        checks++; if (n_out_valid !== 1'b0) begin failures++; $display("FAIL ns_drain got=%0d exp=0", n_out_valid); end
    endtask

    task automatic test_hold();
        do_reset();
        in_valid = 1'b1; data_i = 8'h55; out_ready = 1'b1; hold = 1'b1;
        cyc(1);
        in_valid = 1'b0;
        checks++; if ({a_out_valid, a_stall} !== {1'b1, 16'd0}) begin failures++; $display("FAIL hold_start got=%0d/%0d exp=1/0", a_out_valid, a_stall); end
        for (int k = 0; k < 5; k++) begin
            cyc(1);
            checks++; if (a_data_o !== 8'h55) begin failures++; $display("FAIL hold_data[%0d] got=%0h exp=55", k, a_data_o); end
        end
        checks++; if (a_stall !== 16'd5) begin failures++; $display("FAIL hold_stall got=%0d exp=5", a_stall); end
        checks++; if (a_occ !== 2'd1) begin failures++; $display("FAIL hold_occ got=%0d exp=1", a_occ); end
        hold = 1'b0;
        cyc(1);
        checks++; if ({a_out_valid, a_stall} !== {1'b0, 16'd5}) begin failures++; $display("FAIL hold_release got=%0d/%0d exp=0/5", a_out_valid, a_stall); end
    endtask

    task automatic test_flush();
        do_reset();
        in_valid = 1'b1; data_i = 8'h66;
        cyc(1);
        data_i = 8'h77;
        cyc(1);
        checks++; if (a_occ !== 2'd2) begin failures++; $display("FAIL fl_full got=%0d exp=2", a_occ); end
        flush = 1'b1; data_i = 8'h33;
        cyc(1);
        flush = 1'b0; in_valid = 1'b0;
        checks++; if ({a_occ, a_out_valid, a_in_ready} !== 4'b0001) begin failures++; $display("FAIL fl_full_kill got=%0d/%0d/%0d exp=0/0/1", a_occ, a_out_valid, a_in_ready); end
        checks++; if (a_stall !== 16'd1) begin failures++; $display("FAIL fl_stall got=%0d exp=1", a_stall); end
        out_ready = 1'b1;
        cyc(2);
        checks++; if (a_out_valid !== 1'b0) begin failures++; $display("FAIL fl_no33 got=%0d exp=0", a_out_valid); end
        out_ready = 1'b0; in_valid = 1'b1; data_i = 8'h66;
        cyc(1);
        checks++; if (a_occ !== 2'd1) begin failures++; $display("FAIL fl_one got=%0d exp=1", a_occ); end
        flush = 1'b1; data_i = 8'h33;
        cyc(1);
        flush = 1'b0; in_valid = 1'b0;
        checks++; if ({a_occ, a_out_valid} !== 3'b000) begin failures++; $display("FAIL fl_prio got=%0d/%0d exp=0/0", a_occ, a_out_valid); end
        checks++; if (a_stall !== 16'd1) begin failures++; $display("FAIL fl_stall2 got=%0d exp=1", a_stall); end
        cyc(2);
        checks++; if (a_out_valid !== 1'b0) begin failures++; $display("FAIL fl_no33b got=%0d exp=0", a_out_valid); end
    endtask

    task automatic test_saturate();
        do_reset();
        in_valid = 1'b1; data_i = 8'h99;
        cyc(1);
        in_valid = 1'b0;
        cyc(20);
        checks++; if (c_stall !== 4'hF) begin failures++; $display("FAIL sat_c4 got=%0d exp=15", c_stall); end
        checks++; if (a_stall !== 16'd20) begin failures++; $display("FAIL sat_c16 got=%0d exp=20", a_stall); end
        checks++; if ({c_out_valid, c_data_o} !== {1'b1, 8'h99}) begin failures++; $display("FAIL sat_head got=%0d/%0h exp=1/99", c_out_valid, c_data_o); end
    endtask

    task automatic test_async_reset();
        out_ready = 1'b1; in_valid = 1'b1;
        for (int k = 1; k <= 3; k++) begin
            data_i = 8'(8'hC0 + k);
            cyc(1);
        end
        rst = 1'b0;
        #1;
        checks++; if ({a_out_valid, a_occ, a_in_ready} !== 4'b0001) begin failures++; $display("FAIL ar_state got=%0d/%0d/%0d exp=0/0/1", a_out_valid, a_occ, a_in_ready); end
        checks++; if (a_data_o !== 8'h00) begin failures++; $display("FAIL ar_data got=%0h exp=0", a_data_o); end
        checks++; if ({a_stall, c_stall} !== 20'd0) begin failures++; $display("FAIL ar_stall got=%0d/%0d exp=0/0", a_stall, c_stall); end
        checks++; if (n_in_ready !== 1'b1) begin failures++; $display("FAIL ar_n_ready got=%0d exp=1", n_in_ready); end
        in_valid = 1'b0;
        cyc(1);
        rst = 1'b1;
        cyc(2);
        checks++; if ({a_out_valid, n_out_valid, c_out_valid} !== 3'b000) begin failures++; $display("FAIL ar_release got=%0d%0d%0d exp=000", a_out_valid, n_out_valid, c_out_valid); end
    endtask

    initial begin
        test_reset();
        test_single();
        test_back_to_back();
        test_backpressure();
        test_noskid();
        test_hold();
        test_flush();
        test_saturate();
        test_async_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
